// File: rtl/param_control_fsm.sv
// Multi-cycle instruction sequencer: fetches an opcode/Rx/Ry word, steps T1..T3 to
// steer a datapath, and counts completed instructions. Outputs decode state + IR only.
module param_control_fsm #(
  parameter  int DATA_W   = 16,
  parameter  int RA_W     = 3,
  localparam int NUM_REGS = 2**RA_W
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                instr_valid,
  input  logic [DATA_W-1:0]   instr,
  input  logic                resume,
  output logic                instr_ready,
  output logic                reg_a_en,
  output logic                reg_r_en,
  output logic                mux_sel_a,
  output logic                mux_sel_b,
  output logic [2:0]          alu_op,
  output logic [RA_W-1:0]     rd_addr_x,
  output logic [RA_W-1:0]     rd_addr_y,
  output logic [NUM_REGS-1:0] rf_we,
  output logic                bus_oe,
  output logic                done,
  output logic                illegal_op,
  output logic                halted,
  output logic [15:0]         instr_count
);

  if (DATA_W < 3 + 2*RA_W) begin : g_bad_params
    $error("param_control_fsm: DATA_W must be >= 3 + 2*RA_W");
  end

  localparam logic [2:0] OP_ADD = 3'b000, OP_SUB = 3'b001, OP_NAN = 3'b010,
                         OP_BAD = 3'b011, OP_OUT = 3'b100, OP_LDI = 3'b101,
                         OP_HLT = 3'b110, OP_REP = 3'b111;

  typedef enum logic [2:0] {IDLE, T1, T2, T3, HALTED, ILL} state_t;

  state_t          state, state_nxt;
  logic [2:0]      ir_op;
  logic [RA_W-1:0] ir_rx, ir_ry;
  logic [2:0]      in_op;
  logic            unused_instr;

  assign in_op        = instr[DATA_W-1 -: 3];
  assign unused_instr = ^instr;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state       <= IDLE;
      ir_op       <= '0;
      ir_rx       <= '0;
      ir_ry       <= '0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && instr_valid) begin
        ir_op <= in_op;
        ir_rx <= instr[DATA_W-4 -: RA_W];
        ir_ry <= instr[DATA_W-4-RA_W -: RA_W];
      end
      if (state == T3) instr_count <= instr_count + 16'd1;
    end
  end

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    reg_a_en    = 1'b0;
    reg_r_en    = 1'b0;
    mux_sel_a   = 1'b0;
    mux_sel_b   = 1'b0;
    alu_op      = 3'b000;
    rf_we       = '0;
    bus_oe      = 1'b0;
    done        = 1'b0;
    illegal_op  = 1'b0;
    halted      = 1'b0;
    rd_addr_x   = ir_rx;
    rd_addr_y   = ir_ry;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          case (in_op)
            OP_HLT:  state_nxt = HALTED;
            OP_BAD:  state_nxt = ILL;
            default: state_nxt = T1;
          endcase
        end
      end
      T1: begin
        reg_a_en  = 1'b1;
        mux_sel_a = (ir_op == OP_LDI);
        state_nxt = T2;
      end
      T2: begin
        reg_r_en = (ir_op != OP_OUT);
        case (ir_op)
          OP_SUB:  alu_op = 3'b001;
          OP_NAN:  alu_op = 3'b010;
          OP_LDI:  begin alu_op = 3'b011; mux_sel_b = 1'b1; end
          OP_REP:  alu_op = 3'b100;
          default: alu_op = 3'b000;
        endcase
        state_nxt = T3;
      end
      T3: begin
        done      = 1'b1;
        bus_oe    = (ir_op == OP_OUT);
        // OUT only drives the bus; it never writes back
        if (ir_op != OP_OUT) rf_we = NUM_REGS'(1) << ir_rx;
        state_nxt = IDLE;
      end
      HALTED: begin
        halted = 1'b1;
        if (resume) state_nxt = IDLE;
      end
      ILL: begin
        illegal_op = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_param_control_fsm.sv
// Directed bench for param_control_fsm (DATA_W=16, RA_W=3) with hand-computed expectations.
module tb_param_control_fsm;
  logic        clock = 1'b0;
  logic        resetn;
  logic        instr_valid;
  logic [15:0] instr;
  logic        resume;
  logic        instr_ready, reg_a_en, reg_r_en, mux_sel_a, mux_sel_b;
  logic [2:0]  alu_op;
  logic [2:0]  rd_addr_x, rd_addr_y;
  logic [7:0]  rf_we;
  logic        bus_oe, done, illegal_op, halted;
  logic [15:0] instr_count;

  int n_cmp = 0;
  int n_err = 0;

  param_control_fsm #(.DATA_W(16), .RA_W(3)) dut (
    .clock(clock), .resetn(resetn), .instr_valid(instr_valid), .instr(instr),
    .resume(resume), .instr_ready(instr_ready), .reg_a_en(reg_a_en),
    .reg_r_en(reg_r_en), .mux_sel_a(mux_sel_a), .mux_sel_b(mux_sel_b),
    .alu_op(alu_op), .rd_addr_x(rd_addr_x), .rd_addr_y(rd_addr_y), .rf_we(rf_we),
    .bus_oe(bus_oe), .done(done), .illegal_op(illegal_op), .halted(halted),
    .instr_count(instr_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one edge and settle; outputs then reflect the new state
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // every control output at once: ready,a_en,r_en,sel_a,sel_b,alu,rf_we,oe,done,ill,halt
  function automatic logic [31:0] ctl();
    return {11'd0, instr_ready, reg_a_en, reg_r_en, mux_sel_a, mux_sel_b, alu_op,
            rf_we, bus_oe, done, illegal_op, halted};
  endfunction

  function automatic logic [31:0] mk(input logic rdy, a, r, sa, sb, input logic [2:0] op,
                                     input logic [7:0] we, input logic oe, dn, il, hl);
    return {11'd0, rdy, a, r, sa, sb, op, we, oe, dn, il, hl};
  endfunction

  initial begin
    resetn = 1'b0; instr_valid = 1'b0; instr = '0; resume = 1'b0;
    #12;
    chk("reset_ctl",   ctl(), mk(1,0,0,0,0,3'd0,8'h00,0,0,0,0));
    chk("reset_count", instr_count, 16'd0);
    chk("reset_addr",  {rd_addr_x, rd_addr_y}, 6'd0);
    resetn = 1'b1;
    @(posedge clock); #1;

    // ADD R2,R5
    instr = 16'h0A80; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    chk("add_t1",   ctl(), mk(0,1,0,0,0,3'd0,8'h00,0,0,0,0));
    chk("add_addr", {rd_addr_x, rd_addr_y}, {3'd2, 3'd5});
    step(); chk("add_t2", ctl(), mk(0,0,1,0,0,3'd0,8'h00,0,0,0,0));
    step(); chk("add_t3", ctl(), mk(0,0,0,0,0,3'd0,8'h04,0,1,0,0));
    chk("add_t3_ry", rd_addr_y, 3'd5);
    step(); chk("add_idle", ctl(), mk(1,0,0,0,0,3'd0,8'h00,0,0,0,0));
    chk("add_count", instr_count, 16'd1);

    // LDI R7
    instr = 16'hBC00; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    chk("ldi_t1", ctl(), mk(0,1,0,1,0,3'd0,8'h00,0,0,0,0));
    step(); chk("ldi_t2", ctl(), mk(0,0,1,0,1,3'd3,8'h00,0,0,0,0));
    step(); chk("ldi_t3", ctl(), mk(0,0,0,0,0,3'd0,8'h80,0,1,0,0));
    step(); chk("ldi_count", instr_count, 16'd2);

    // OUT R1
    instr = 16'h8400; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    step(); chk("out_t2", ctl(), mk(0,0,0,0,0,3'd0,8'h00,0,0,0,0));
    step(); chk("out_t3", ctl(), mk(0,0,0,0,0,3'd0,8'h00,1,1,0,0));
    step(); chk("out_count", instr_count, 16'd3);

    // NAN R4,R0 then REP R6,R3, back to back with valid held high
    instr = 16'h5000; instr_valid = 1'b1;
    step(); step(); chk("nan_t2", ctl(), mk(0,0,1,0,0,3'd2,8'h00,0,0,0,0));
    step(); chk("nan_t3", rf_we, 8'h10);
    instr = 16'hF980;
    step(); chk("nan_idle_ready", instr_ready, 1'b1);
    step(); instr_valid = 1'b0;
    chk("rep_t1_addr", {rd_addr_x, rd_addr_y}, {3'd6, 3'd3});
    step(); chk("rep_t2", ctl(), mk(0,0,1,0,0,3'd4,8'h00,0,0,0,0));
    step(); chk("rep_t3", rf_we, 8'h40);
    step(); chk("rep_count", instr_count, 16'd5);

    // resume outside HALTED has no effect
    resume = 1'b1;
    step(); chk("resume_idle", ctl(), mk(1,0,0,0,0,3'd0,8'h00,0,0,0,0));
    resume = 1'b0;

    // HALT with valid held high: nothing accepted until resume
    instr = 16'hC000; instr_valid = 1'b1;
    step(); chk("halt_enter", ctl(), mk(0,0,0,0,0,3'd0,8'h00,0,0,0,1));
    instr = 16'h0A80;
    step(); step(); chk("halt_hold", ctl(), mk(0,0,0,0,0,3'd0,8'h00,0,0,0,1));
    chk("halt_count", instr_count, 16'd5);
    resume = 1'b1; instr_valid = 1'b0;
    step(); resume = 1'b0;
    chk("halt_resume", ctl(), mk(1,0,0,0,0,3'd0,8'h00,0,0,0,0));

    // illegal opcode 011
    instr = 16'h6000; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    chk("ill_pulse", ctl(), mk(0,0,0,0,0,3'd0,8'h00,0,0,1,0));
    chk("ill_count", instr_count, 16'd5);
    step(); chk("ill_idle", ctl(), mk(1,0,0,0,0,3'd0,8'h00,0,0,0,0));
    chk("ill_count2", instr_count, 16'd5);

    // SUB R3,R4 interrupted by reset during T2
    instr = 16'h2E00; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    step(); chk("sub_t2", ctl(), mk(0,0,1,0,0,3'd1,8'h00,0,0,0,0));
    #2 resetn = 1'b0;
    #1;
    chk("rst_mid_ctl",   ctl(), mk(1,0,0,0,0,3'd0,8'h00,0,0,0,0));
    chk("rst_mid_count", instr_count, 16'd0);
    chk("rst_mid_addr",  {rd_addr_x, rd_addr_y}, 6'd0);
    #2 resetn = 1'b1;
    instr = 16'h0A80; instr_valid = 1'b1;
    step(); instr_valid = 1'b0;
    chk("post_rst_t1", ctl(), mk(0,1,0,0,0,3'd0,8'h00,0,0,0,0));
    step(); step(); step();
    chk("post_rst_count", instr_count, 16'd1);

    // wrap: clear, run 65535 ADDs back to back, then one more
    resetn = 1'b0; #2; resetn = 1'b1;
    instr = 16'h0A80; instr_valid = 1'b1;
    repeat (65535 * 4) @(posedge clock);
    #1;
    chk("preload_count", instr_count, 16'hFFFF);
    chk("preload_idle",  instr_ready, 1'b1);
    step(); instr_valid = 1'b0;
    step(); step(); step();
    chk("wrap_count", instr_count, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
